vram_slot_arbiter: RTL and testbench

- Time-slot arbiter between the 68010 video-processor bus and the video fetch engine, sharing one synchronous VRAM.
- Consumes the CPU-side VRAM strobes (VRAM_b, VRAMRD_b, VRAMWR, UDS_b/LDS_b) and returns VRDTACK_b and VRAC2 to the DTACK/wait logic.
- Video gets fixed priority slots; the CPU gets a guaranteed slot each frame of slots, plus any video slot left idle.

---
 rtl/vram_slot_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_vram_slot_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing one synchronous VRAM between the 68010 video bus and the video fetch engine.
// Video owns slots 0-2 on demand, slot 3 is reserved for the CPU, and idle video slots fall back to the CPU.
module vram_slot_arbiter #(
    parameter int VADDR_W     = 14,
    parameter int DATA_W      = 16,
    parameter int SLOT_CYCLES = 4
) (
    input  logic                           MCKR,
    input  logic                           SYSRES,
    input  logic                           VRAM_b,
    input  logic                           VRAMRD_b,
    input  logic                           VRAMWR,
    input  logic                           UDS_b,
    input  logic                           LDS_b,
    input  logic [VADDR_W-1:0]             CPU_A,
    input  logic [DATA_W-1:0]              CPU_D_in,
    output logic [DATA_W-1:0]              CPU_D_out,
    output logic                           VRDTACK_b,
    output logic                           VRAC2,
    input  logic                           VID_REQ,
    input  logic [VADDR_W-1:0]             VID_A,
    output logic                           VID_GNT,
    output logic                           VID_VALID,
    output logic [DATA_W-1:0]              VID_D,
    output logic [VADDR_W-1:0]             RAM_A,
    output logic                           RAM_WH_b,
    output logic                           RAM_WL_b,
    output logic [DATA_W-1:0]              RAM_D_out,
    input  logic [DATA_W-1:0]              RAM_D_in,
    output logic [1:0]                     dbg_cpu_state,
    output logic [$clog2(SLOT_CYCLES)-1:0] dbg_cyc,
    output logic [1:0]                     dbg_slot
);
    localparam int CYC_W = $clog2(SLOT_CYCLES);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(SLOT_CYCLES / 2);
    localparam logic [CYC_W-1:0] CYC_ACK  = CYC_W'(2);

    typedef enum logic [1:0] {
        CPU_IDLE   = 2'd0,
        CPU_PEND   = 2'd1,
        CPU_ACCESS = 2'd2,
        CPU_ACK    = 2'd3
    } cpu_state_t;

    cpu_state_t          state_q, state_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [1:0]          slot_q, slot_d;
    logic                wr_q, wr_d;
    logic                lane_h_q, lane_h_d;
    logic                lane_l_q, lane_l_d;
    logic                vrdtack_b_q, vrdtack_b_d;
    logic [VADDR_W-1:0]  ram_a_q, ram_a_d;
    logic                ram_wh_b_q, ram_wh_b_d;
    logic                ram_wl_b_q, ram_wl_b_d;
    logic [DATA_W-1:0]   ram_d_out_q, ram_d_out_d;
    logic [DATA_W-1:0]   cpu_d_out_q, cpu_d_out_d;
    logic                vid_gnt_q, vid_gnt_d;
    logic                vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0]   vid_d_q, vid_d_d;
    logic                slot_start, vid_own, cpu_own;

    // Every decision is made on the edge that enters cyc 0, so the slot's
    // address and strobes are visible for the whole of cyc 0.
    always_comb begin
        cyc_d       = (cyc_q == CYC_LAST) ? '0 : cyc_q + CYC_W'(1);
        slot_d      = (cyc_q == CYC_LAST) ? slot_q + 2'd1 : slot_q;
        slot_start  = (cyc_d == '0);
        vid_own     = slot_start && VID_REQ && (slot_d != 2'd3);
        cpu_own     = slot_start && !vid_own && (state_q == CPU_PEND) && !VRAM_b;

        state_d     = state_q;
        wr_d        = wr_q;
        lane_h_d    = lane_h_q;
        lane_l_d    = lane_l_q;
        vrdtack_b_d = vrdtack_b_q;
        ram_a_d     = ram_a_q;
        ram_wh_b_d  = 1'b1;
        ram_wl_b_d  = 1'b1;
        ram_d_out_d = ram_d_out_q;
        cpu_d_out_d = cpu_d_out_q;
        vid_gnt_d   = 1'b0;
        vid_valid_d = 1'b0;
        vid_d_d     = vid_d_q;

        if (vid_own) begin
            ram_a_d   = VID_A;
            vid_gnt_d = 1'b1;
        end
        if (vid_gnt_q) begin
            vid_d_d     = RAM_D_in;
            vid_valid_d = 1'b1;
        end

        case (state_q)
            CPU_IDLE: begin
                if (!VRAM_b && (!VRAMRD_b || VRAMWR)) begin
                    state_d  = CPU_PEND;
                    wr_d     = VRAMWR;
                    lane_h_d = ~UDS_b;
                    lane_l_d = ~LDS_b;
                end
            end
            CPU_PEND: begin
                if (VRAM_b) begin
                    state_d = CPU_IDLE;
                end else if (cpu_own) begin
                    state_d = CPU_ACCESS;
                    ram_a_d = CPU_A;
                    if (wr_q) begin
                        ram_d_out_d = CPU_D_in;
                        ram_wh_b_d  = ~lane_h_q;
                        ram_wl_b_d  = ~lane_l_q;
                    end
                end
            end
            CPU_ACCESS: begin
                if (cyc_q == '0 && !wr_q) begin
                    cpu_d_out_d = RAM_D_in;
                end
                if (cyc_d == CYC_ACK) begin
                    state_d     = CPU_ACK;
                    vrdtack_b_d = 1'b0;
                end
            end
            CPU_ACK: begin
                if (VRAM_b) begin
                    state_d     = CPU_IDLE;
                    vrdtack_b_d = 1'b1;
                end
            end
            default: state_d = CPU_IDLE;
        endcase
    end

    always_ff @(posedge MCKR or posedge SYSRES) begin
        if (SYSRES) begin
            state_q     <= CPU_IDLE;
            cyc_q       <= '0;
            slot_q      <= '0;
            wr_q        <= 1'b0;
            lane_h_q    <= 1'b0;
            lane_l_q    <= 1'b0;
            vrdtack_b_q <= 1'b1;
            ram_a_q     <= '0;
            ram_wh_b_q  <= 1'b1;
            ram_wl_b_q  <= 1'b1;
            ram_d_out_q <= '0;
            cpu_d_out_q <= '0;
            vid_gnt_q   <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_d_q     <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            slot_q      <= slot_d;
            wr_q        <= wr_d;
            lane_h_q    <= lane_h_d;
            lane_l_q    <= lane_l_d;
            vrdtack_b_q <= vrdtack_b_d;
            ram_a_q     <= ram_a_d;
            ram_wh_b_q  <= ram_wh_b_d;
            ram_wl_b_q  <= ram_wl_b_d;
            ram_d_out_q <= ram_d_out_d;
            cpu_d_out_q <= cpu_d_out_d;
            vid_gnt_q   <= vid_gnt_d;
            vid_valid_q <= vid_valid_d;
            vid_d_q     <= vid_d_d;
        end
    end

    assign VRAC2         = (cyc_q < CYC_HALF);
    assign CPU_D_out     = cpu_d_out_q;
    assign VRDTACK_b     = vrdtack_b_q;
    assign VID_GNT       = vid_gnt_q;
    assign VID_VALID     = vid_valid_q;
    assign VID_D         = vid_d_q;
    assign RAM_A         = ram_a_q;
    assign RAM_WH_b      = ram_wh_b_q;
    assign RAM_WL_b      = ram_wl_b_q;
    assign RAM_D_out     = ram_d_out_q;
    assign dbg_cpu_state = state_q;
    assign dbg_cyc       = cyc_q;
    assign dbg_slot      = slot_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Bench for vram_slot_arbiter: reference slot counters, a VRAM model, and scoreboards
// for video fetch data and VRAM writes.
`timescale 1ns/1ps
module tb_vram_slot_arbiter;
    localparam int VADDR_W = 14;
    localparam int DATA_W  = 16;
    localparam int SC      = 4;
    localparam int WR_W    = VADDR_W + DATA_W + 2;

    logic                mckr = 1'b0;
    logic                sysres = 1'b1;
    logic                vram_b = 1'b1, vramrd_b = 1'b1, vramwr = 1'b0;
    logic                uds_b = 1'b1, lds_b = 1'b1;
    logic [VADDR_W-1:0]  cpu_a = '0, vid_a = '0, vid_a_s;
    logic [DATA_W-1:0]   cpu_d_in = '0;
    logic                vid_req = 1'b0;
    logic [DATA_W-1:0]   cpu_d_out, vid_d, ram_d_out, ram_d_in;
    logic                vrdtack_b, vrac2, vid_gnt, vid_valid, ram_wh_b, ram_wl_b;
    logic [VADDR_W-1:0]  ram_a;
    logic [1:0]          dbg_cpu_state, dbg_slot;
    logic [1:0]          dbg_cyc;

    logic [DATA_W-1:0]   mem [0:(1<<VADDR_W)-1];
    logic [DATA_W-1:0]   exp_vid_q[$];
    logic [WR_W-1:0]     exp_wr_q[$];

    int n_checks = 0, n_fail = 0;
    int ref_cyc, ref_slot;
    int gnt_cnt = 0, valid_cnt = 0, wr_slot = -1;
    int gnt_at_ack, valid_at_ack, wr_slot_at_ack;
    logic chk_cnt = 1'b0;

    always #5 mckr = ~mckr;

    vram_slot_arbiter #(.VADDR_W(VADDR_W), .DATA_W(DATA_W), .SLOT_CYCLES(SC)) dut (
        .MCKR(mckr), .SYSRES(sysres), .VRAM_b(vram_b), .VRAMRD_b(vramrd_b), .VRAMWR(vramwr),
        .UDS_b(uds_b), .LDS_b(lds_b), .CPU_A(cpu_a), .CPU_D_in(cpu_d_in), .CPU_D_out(cpu_d_out),
        .VRDTACK_b(vrdtack_b), .VRAC2(vrac2), .VID_REQ(vid_req), .VID_A(vid_a), .VID_GNT(vid_gnt),
        .VID_VALID(vid_valid), .VID_D(vid_d), .RAM_A(ram_a), .RAM_WH_b(ram_wh_b), .RAM_WL_b(ram_wl_b),
        .RAM_D_out(ram_d_out), .RAM_D_in(ram_d_in), .dbg_cpu_state(dbg_cpu_state),
        .dbg_cyc(dbg_cyc), .dbg_slot(dbg_slot)
    );

    // Read data follows the registered address by one cycle.
    assign ram_d_in = mem[ram_a];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference slot timing, independent of the DUT.
    always @(posedge mckr or posedge sysres) begin
        if (sysres) begin
            ref_cyc  <= 0;
            ref_slot <= 0;
            vid_a_s  <= '0;
        end else begin
            ref_cyc  <= (ref_cyc == SC - 1) ? 0 : ref_cyc + 1;
            if (ref_cyc == SC - 1) ref_slot <= (ref_slot + 1) % 4;
            vid_a_s  <= vid_a;
        end
    end

    always @(negedge mckr) begin
        if (!sysres) begin
            if (chk_cnt) begin
                check("cyc", 32'(dbg_cyc), ref_cyc);
                check("slot", 32'(dbg_slot), ref_slot);
                check("vrac2", vrac2, ref_cyc < SC / 2);
            end
            if (vid_gnt) begin
                gnt_cnt++;
                check("gnt_cyc", ref_cyc, 0);
                check("gnt_not_slot3", ref_slot != 3, 1);
                check("gnt_addr", 32'(ram_a), 32'(vid_a_s));
                exp_vid_q.push_back(mem[vid_a_s]);
            end
            if (vid_valid) begin
                valid_cnt++;
                check("valid_cyc", ref_cyc, 1);
                check("vid_expected", exp_vid_q.size() != 0, 1);
                if (exp_vid_q.size() != 0) check("vid_d", 32'(vid_d), 32'(exp_vid_q.pop_front()));
            end
            if (!ram_wh_b || !ram_wl_b) begin
                wr_slot = ref_slot;
                check("wr_cyc", ref_cyc, 0);
                check("wr_expected", exp_wr_q.size() != 0, 1);
                if (exp_wr_q.size() != 0)
                    check("wr", 32'({ram_a, ram_d_out, ram_wh_b, ram_wl_b}), 32'(exp_wr_q.pop_front()));
                if (!ram_wh_b) mem[ram_a][15:8] = ram_d_out[15:8];
                if (!ram_wl_b) mem[ram_a][7:0]  = ram_d_out[7:0];
            end
        end
    end

    task automatic cpu_start(input logic wr, input logic [VADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic ub, input logic lb, input logic expect_wr);
        vram_b   = 1'b0;
        vramrd_b = wr;
        vramwr   = wr;
        uds_b    = ub;
        lds_b    = lb;
        cpu_a    = a;
        cpu_d_in = d;
        if (wr && expect_wr) exp_wr_q.push_back({a, d, ub, lb});
    endtask

    task automatic cpu_release();
        vram_b   = 1'b1;
        vramrd_b = 1'b1;
        vramwr   = 1'b0;
        uds_b    = 1'b1;
        lds_b    = 1'b1;
    endtask

    // Full CPU transaction started just after a falling edge.
    task automatic cpu_txn(input logic wr, input logic [VADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic ub, input logic lb, input int max_lat);
        int n = 0;
        logic seen = 1'b0;
        cpu_start(wr, a, d, ub, lb, 1'b1);
        while (!seen && n < 4 * SC + 6) begin
            @(negedge mckr);
            n++;
            seen = !vrdtack_b;
        end
        check("ack_seen", seen, 1);
        check("ack_latency", (n - 1) <= max_lat, 1);
        check("ack_cyc", ref_cyc, 2);
        gnt_at_ack     = gnt_cnt;
        valid_at_ack   = valid_cnt;
        wr_slot_at_ack = wr_slot;
        if (!wr) check("rd_data", 32'(cpu_d_out), 32'(mem[a]));
        @(negedge mckr);
        check("ack_hold", vrdtack_b, 0);
        cpu_release();
        @(negedge mckr);
        check("ack_release", vrdtack_b, 1);
        check("idle_after_ack", 32'(dbg_cpu_state), 0);
    endtask

    task automatic wait_phase(input int s, input int c);
        int n = 0;
        do begin
            @(negedge mckr);
            n++;
        end while (!(ref_slot == s && ref_cyc == c) && n < 12 * SC);
        check("phase_reached", ref_slot == s && ref_cyc == c, 1);
    endtask

    initial begin
        int ack_low, n;
        logic seen;
        for (int i = 0; i < (1 << VADDR_W); i++) mem[i] = 16'(i * 37) ^ 16'h3C5A;
        mem[14'h0123] = 16'hBEEF;
        mem[14'h1FFF] = 16'h00FF;

        #12;
        check("rst_vrdtack", vrdtack_b, 1);
        check("rst_wh", ram_wh_b, 1);
        check("rst_wl", ram_wl_b, 1);
        check("rst_gnt", vid_gnt, 0);
        check("rst_valid", vid_valid, 0);
        check("rst_cpu_d", 32'(cpu_d_out), 0);
        check("rst_vid_d", 32'(vid_d), 0);
        check("rst_ram_a", 32'(ram_a), 0);
        check("rst_ram_d", 32'(ram_d_out), 0);
        check("rst_vrac2", vrac2, 1);
        check("rst_cyc", 32'(dbg_cyc), 0);
        check("rst_slot", 32'(dbg_slot), 0);
        check("rst_state", 32'(dbg_cpu_state), 0);
        @(negedge mckr);
        sysres = 1'b0;

        // Counter and VRAC2 wrap over two frames.
        chk_cnt = 1'b1;
        repeat (8 * SC) @(negedge mckr);
        chk_cnt = 1'b0;

        // CPU read with no video traffic: served at the next slot start.
        cpu_txn(1'b0, 14'h0123, 16'h0, 1'b0, 1'b0, SC + 2);

        // Video holds slots 0-2; CPU low-byte write lands in slot 3.
        vid_a = 14'h1FFF;
        wait_phase(3, 2);
        gnt_cnt   = 0;
        valid_cnt = 0;
        vid_req   = 1'b1;
        wait_phase(0, 1);
        cpu_txn(1'b1, 14'h0040, 16'h5A5A, 1'b1, 1'b0, 4 * SC + 2);
        check("vid_gnt_count", gnt_at_ack, 3);
        check("vid_valid_count", valid_at_ack, 3);
        check("cpu_wr_slot", wr_slot_at_ack, 3);
        check("mem_low_byte", 32'(mem[14'h0040]), 32'({8'(16'(14'h0040 * 37) >> 8) ^ 8'h3C, 8'h5A}));

        // Mixed random traffic.
        for (int k = 0; k < 8; k++) begin
            vid_a   = 14'($urandom_range(0, (1 << VADDR_W) - 1));
            vid_req = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) @(negedge mckr);
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(0, 2);
                cpu_txn(1'b1, 14'($urandom_range(0, (1 << VADDR_W) - 1)), 16'($urandom),
                        1'(n == 1), 1'(n == 2), 4 * SC + 2);
            end else begin
                cpu_txn(1'b0, 14'($urandom_range(0, (1 << VADDR_W) - 1)), 16'h0, 1'b0, 1'b0, 4 * SC + 2);
            end
        end

        // Abandoned write while video holds the bus.
        vid_req = 1'b1;
        wait_phase(0, 1);
        cpu_start(1'b1, 14'h0200, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        repeat (SC) @(negedge mckr);
        cpu_release();
        @(negedge mckr);
        check("abandon_idle", 32'(dbg_cpu_state), 0);
        ack_low = 0;
        repeat (8 * SC) begin
            @(negedge mckr);
            if (!vrdtack_b) ack_low++;
        end
        check("abandon_no_ack", ack_low, 0);
        vid_req = 1'b0;

        // Reset asserted while a write strobe is on the bus.
        @(negedge mckr);
        cpu_start(1'b1, 14'h0300, 16'h1234, 1'b0, 1'b0, 1'b1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 4 * SC + 4) begin
            @(negedge mckr);
            n++;
            seen = !ram_wh_b || !ram_wl_b;
        end
        check("rst_mid_wr_seen", seen, 1);
        #2 sysres = 1'b1;
        #1;
        check("async_wh", ram_wh_b, 1);
        check("async_wl", ram_wl_b, 1);
        check("async_vrdtack", vrdtack_b, 1);
        check("async_ram_a", 32'(ram_a), 0);
        cpu_release();
        @(negedge mckr);
        sysres = 1'b0;
        #1;
        check("post_rst_cyc", 32'(dbg_cyc), 0);
        check("post_rst_slot", 32'(dbg_slot), 0);
        check("post_rst_state", 32'(dbg_cpu_state), 0);

        repeat (2 * SC) @(negedge mckr);
        check("vid_queue_empty", exp_vid_q.size(), 0);
        check("wr_queue_empty", exp_wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
